// File: rtl/s386_resp_logger_if.sv
// Bus bundle between the s386 response logger and its producer/consumer.
// The master drives sampling and drain controls; the slave (logger) returns the FIFO head.
interface s386_resp_logger_if #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TS_W  = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            EN;
   logic [6:0]      d_in;
   logic            clr_ovf;
   logic            ev_ready;
   logic            ev_valid;
   logic [6:0]      ev_word;
   logic [TS_W-1:0] ev_ts;
   logic [CW-1:0]   ev_count;
   logic            ev_ovf;

   modport master (
      output EN, d_in, clr_ovf, ev_ready,
      input  ev_valid, ev_word, ev_ts, ev_count, ev_ovf
   );

   modport slave (
      input  EN, d_in, clr_ovf, ev_ready,
      output ev_valid, ev_word, ev_ts, ev_count, ev_ovf
   );
endinterface

// File: rtl/s386_resp_logger.sv
// Change logger for the s386 primary outputs: timestamps every change of d_in and queues it
// in a show-ahead FIFO drained over a valid/ready handshake.
module s386_resp_logger #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TS_W  = 16
) (
   input logic               CK,
   input logic               RST,
   s386_resp_logger_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 7 + TS_W;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   logic [TS_W-1:0] ts_q, ts_d;
   logic [6:0]      prev_q, prev_d;
   logic [CW-1:0]   wptr_q, wptr_d;
   logic [CW-1:0]   rptr_q, rptr_d;
   logic            ovf_q, ovf_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic [CW-1:0]   count;
   logic            valid;
   logic            full;
   logic            change;
   logic            pop;
   logic            push;
   logic            drop;
   logic [EW-1:0]   head;

   assign count = wptr_q - rptr_q;
   assign valid = (count != '0);
   assign full  = (count == FullCnt);
   assign head  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      change = bus.EN && (bus.d_in != prev_q);
      pop    = valid && bus.ev_ready;
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push   = change && (!full || pop);
      drop   = change && full && !pop;

      ts_d   = ts_q;
      prev_d = prev_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;

      if (bus.EN) begin
         ts_d   = ts_q + TS_W'(1);
         prev_d = bus.d_in;
      end
      if (push) wptr_d = wptr_q + CW'(1);
      if (pop)  rptr_d = rptr_q + CW'(1);

      // Set wins over clear when a drop coincides with clr_ovf.
      if (drop)             ovf_d = 1'b1;
      else if (bus.clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         ts_q   <= '0;
         prev_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ts_q   <= ts_d;
         prev_q <= prev_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
      end
   end

   // Storage needs no reset; entries are only visible between valid pointers.
   always_ff @(posedge CK) begin
      if (!RST && push) mem_q[wptr_q[AW-1:0]] <= {bus.d_in, ts_q};
   end

   assign bus.ev_valid = valid;
   assign bus.ev_count = count;
   assign bus.ev_ovf   = ovf_q;
   assign bus.ev_word  = valid ? head[EW-1:TS_W] : 7'h00;
   assign bus.ev_ts    = valid ? head[TS_W-1:0] : '0;
endmodule
